prvp_spi_master_reg_access: RTL
===============================

# prvp_spi_master_reg_access

SPI/QPI master that issues configuration-register write and read transactions to the c2c SPI slave's 4-entry register file. It sits on the host side of the chip-to-chip link and turns single-beat host requests into framed SPI mode-0 transactions. It keeps shadow copies of the slave's QPI-enable, dummy-cycle and wrap-length registers, so later transactions use the correct lane width. Downstream memory-access logic reads the same shadows.

## Interface
Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles (D); legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  block idle and able to accept a request
- req_write  in  1  1 = register write, 0 = register read
- req_addr  in  2  slave register index 0..3
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse when a transaction completes
- rsp_rdata  out  8  read data; holds its value until the next read completes
- spi_sck  out  1  SPI clock, idles low
- spi_csn  out  1  chip select, active low
- spi_sdo  out  4  output lanes
- spi_oe  out  4  per-lane output enable
- spi_sdi  in  4  input lanes
- shadow_qpi  out  1  mirror of slave reg0[0]
- shadow_dummy  out  8  mirror of slave reg1
- shadow_wrap  out  16  mirror of {reg3, reg2}

## Operation
- Command byte: write = 8'h10 | addr; read = 8'h20 | addr. Register reads have no dummy cycles.
- Frame: command byte, then one data byte. On writes the master drives the data byte; on reads the slave drives it.
- Bit order is MSB first.
  - Single mode (shadow_qpi=0): bits go out on sdo[0], read data comes in on sdi[1]. One bit per pulse, N = 16 pulses.
  - QPI mode: high nibble first on sdo/sdi[3:0], N = 4 pulses.
- Lane mode is latched at request acceptance. A reg0 write is sent in the old mode; the new mode applies from the next request.
- spi_oe:
  - 0 while idle.
  - Single mode: 4'b0001 for the whole frame.
  - QPI: 4'hF during the command and write data, 4'h0 during read data. Lanes turn around at the falling edge after the last command pulse.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch the request and go to SETUP.
  - SETUP: D cycles, csn low, sck low, first bits driven. Then go to SHIFT.
  - SHIFT: N pulses, each D cycles high then D cycles low. After the last falling edge go to HOLD.
  - HOLD: D cycles, sck low. Then raise csn, pulse rsp_valid and go to GAP.
  - GAP: D cycles, csn high. Then go to IDLE.
- Shadow update happens in the rsp_valid cycle of a write:
  - addr 0 → shadow_qpi = wdata[0]
  - addr 1 → shadow_dummy
  - addr 2 → wrap[7:0]
  - addr 3 → wrap[15:8]
- Reads never update the shadows.
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0
  - spi_csn=1, spi_sck=0, spi_sdo=0, spi_oe=0
  - shadow_qpi=0, shadow_dummy=32, shadow_wrap=0 (these match the slave's reset state)
- rst mid-transaction: all of the above apply on the next edge and the FSM returns to IDLE. No rsp_valid is produced for the aborted transaction. No shadow is updated. csn rises immediately.

## Timing
- Request accepted at edge T (req_valid && req_ready). req_ready drops at T+1.
- spi_csn falls at T+1, and the first bits are valid at T+1.
- Pulse k (0..N-1):
  - spi_sck rises at T+1+D+2Dk; spi_sdi is captured on that clk edge.
  - spi_sck falls at T+1+2D+2Dk; the next bits launch on that same edge.
- spi_csn rises at T+1+2DN+D. rsp_valid and the final rsp_rdata are valid in that same cycle.
- req_ready returns at T+1+2DN+2D.
  - Single mode, D=1: csn rises at T+34, ready at T+35.
  - QPI mode, D=1: csn rises at T+10, ready at T+11.
- Back-to-back requests are separated by at least D cycles with csn high.
- req_valid while req_ready=0 is ignored; the requester holds it.
- rsp_rdata changes only in the rsp_valid cycle of a read.

## Test plan
- Reset, then idle: csn=1, sck=0, oe=0, shadow_dummy=32, req_ready=1. No sck edges over 100 cycles.
- Single-mode write, addr 1, data 8'hA5, D=1: the bench's slave model captures cmd 8'h11 and data 8'hA5 on rising edges. rsp_valid at T+34, shadow_dummy=8'hA5.
- Single-mode read, addr 2, with the slave driving 8'h3C on sdi[1]: cmd 8'h22 on sdo[0], rsp_rdata=8'h3C at T+34, shadows unchanged.
- Write reg0=8'h01, then read reg3 with the slave returning 8'h7E on sdi[3:0], D=2:
  - The first frame is 16 pulses; shadow_qpi=1 after it.
  - The second frame is 4 pulses with cmd nibbles 2,3 on sdo[3:0].
  - oe goes F→0 after pulse 1.
  - rsp_rdata=8'h7E.
- Write reg2=8'h34, then reg3=8'h12: shadow_wrap=16'h1234.
- Assert rst during SHIFT of a write to reg1:
  - csn=1 and oe=0 on the next edge.
  - No rsp_valid, shadow_dummy=32.
  - The next request completes normally.

Source files
------------

// File: rtl/prvp_spi_master_reg_access.sv
// Host-side SPI/QPI master for the c2c slave's 4-entry config register file.
// Issues one framed write or read per request and mirrors the mode/dummy/wrap registers.
module prvp_spi_master_reg_access #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        spi_sck,
  output logic        spi_csn,
  output logic [3:0]  spi_sdo,
  output logic [3:0]  spi_oe,
  input  logic [3:0]  spi_sdi,
  output logic        shadow_qpi,
  output logic [7:0]  shadow_dummy,
  output logic [15:0] shadow_wrap
);

  // state  | meaning
  // IDLE   | ready for a request
  // SETUP  | csn low, first bits driven, sck low for D cycles
  // SHIFT  | N sck pulses, D cycles high then D cycles low
  // HOLD   | sck low for D cycles before csn rises
  // GAP    | csn high for D cycles before accepting again
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

  logic [2:0]  state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] tx;
  logic [7:0]  rx;
  logic        cap_pend;
  logic        qpi_mode;
  logic        wr;
  logic [1:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  cmd;
  logic [15:0] frame;

  always_comb begin
    cmd   = (req_write ? 8'h10 : 8'h20) | {6'b0, req_addr};
    frame = {cmd, (req_write ? req_wdata : 8'h00)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      tx           <= '0;
      rx           <= '0;
      cap_pend     <= 1'b0;
      qpi_mode     <= 1'b0;
      wr           <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      spi_sck      <= 1'b0;
      spi_csn      <= 1'b1;
      spi_sdo      <= '0;
      spi_oe       <= '0;
      shadow_qpi   <= 1'b0;
      shadow_dummy <= 8'd32;
      shadow_wrap  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            wr        <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            qpi_mode  <= shadow_qpi;
            spi_csn   <= 1'b0;
            spi_sck   <= 1'b0;
            rx        <= '0;
            div_cnt   <= DIV_LD;
            state     <= S_SETUP;
            // tx holds the bits still to be launched after the first beat
            if (shadow_qpi) begin
              spi_sdo <= frame[15:12];
              spi_oe  <= 4'hF;
              tx      <= {frame[11:0], 4'h0};
              bit_cnt <= 4'd3;
            end else begin
              spi_sdo <= {3'b000, frame[15]};
              spi_oe  <= 4'h1;
              tx      <= {frame[14:0], 1'b0};
              bit_cnt <= 4'd15;
            end
          end
        end
        S_SETUP: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            spi_sck  <= 1'b1;
            cap_pend <= 1'b1;
            div_cnt  <= DIV_LD;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // sdi is sampled on the first clk edge that sees sck high
          if (cap_pend) begin
            cap_pend <= 1'b0;
            rx       <= qpi_mode ? {rx[3:0], spi_sdi} : {rx[6:0], spi_sdi[1]};
          end
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (spi_sck) begin
            spi_sck <= 1'b0;
            div_cnt <= DIV_LD;
            if (qpi_mode) begin
              tx <= {tx[11:0], 4'h0};
              // bit_cnt <= 2 means the command byte is fully out on a read
              if (!wr && bit_cnt <= 4'd2) begin
                spi_sdo <= 4'h0;
                spi_oe  <= 4'h0;
              end else begin
                spi_sdo <= tx[15:12];
              end
            end else begin
              tx      <= {tx[14:0], 1'b0};
              spi_sdo <= {3'b000, tx[15]};
            end
            if (bit_cnt == 4'd0) state <= S_HOLD;
            else bit_cnt <= bit_cnt - 4'd1;
          end else begin
            spi_sck  <= 1'b1;
            cap_pend <= 1'b1;
            div_cnt  <= DIV_LD;
          end
        end
        S_HOLD: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            spi_csn   <= 1'b1;
            spi_sdo   <= 4'h0;
            spi_oe    <= 4'h0;
            rsp_valid <= 1'b1;
            div_cnt   <= DIV_LD;
            state     <= S_GAP;
            if (!wr) begin
              rsp_rdata <= rx;
            end else begin
              case (addr_q)
                2'd0:    shadow_qpi         <= wdata_q[0];
                2'd1:    shadow_dummy       <= wdata_q;
                2'd2:    shadow_wrap[7:0]   <= wdata_q;
                default: shadow_wrap[15:8]  <= wdata_q;
              endcase
            end
          end
        end
        S_GAP: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          spi_csn   <= 1'b1;
          spi_sck   <= 1'b0;
          spi_oe    <= 4'h0;
        end
      endcase
    end
  end

endmodule
